// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan controller.
// Segment codes are active-low {dp,g,f,e,d,c,b,a}.
package sevenseg_pkg;

  typedef enum logic {BLANK, DRIVE} scan_state_e;

  localparam logic [7:0] SEG_OFF   = 8'hFF;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  // Hex digits 0..F with the decimal point off
  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/sevenseg_decoder.sv
// Nibble to active-low cathode pattern; suppression darkens the segments
// but leaves the decimal point under dp control.
module sevenseg_decoder
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       suppress,
  output logic [7:0] cathode
);

  logic [7:0] seg;

  always_comb begin
    seg     = HEX_SEG[nibble];
    cathode = {~dp, suppress ? 7'h7F : seg[6:0]};
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed 4-digit display scanner with a blanking gap per slot and a
// double-buffered value that only changes at frame boundaries.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        CPU_RESETN,
  input  logic        enable_i,
  input  logic        blank_lz_i,
  input  logic [15:0] value_i,
  input  logic [3:0]  dp_i,
  input  logic        value_valid_i,
  output logic        value_ready_o,
  output logic [3:0]  anode,
  output logic [7:0]  cathode
);

  localparam int DIGIT_CYCLES = CLK_HZ / REFRESH_HZ;
  localparam int CNT_W        = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DIGIT_CYCLES) begin : g_bad_blank
    $error("sevenseg_scan_ctrl: need 1 <= BLANK_CYCLES < DIGIT_CYCLES");
  end

  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       idx;
  scan_state_e      state;
  logic [15:0]      shadow_val, pend_val;
  logic [3:0]       shadow_dp, pend_dp;
  logic             pend_full;
  logic             wrap, frame_end, lz_zero, suppress;
  logic [7:0]       dec_cathode;

  assign wrap          = (cnt == CNT_LAST);
  assign frame_end     = enable_i & wrap & (idx == 2'd3);
  assign cnt_n         = wrap ? '0 : cnt + 1'b1;
  assign value_ready_o = ~pend_full;

  // A digit is blank when it and every digit to its left are zero
  always_comb begin
    lz_zero = 1'b0;
    case (idx)
      2'd1:    lz_zero = (shadow_val[15:4]  == '0);
      2'd2:    lz_zero = (shadow_val[15:8]  == '0);
      2'd3:    lz_zero = (shadow_val[15:12] == '0);
      default: lz_zero = 1'b0;
    endcase
    suppress = blank_lz_i & lz_zero;
  end

  sevenseg_decoder u_dec (
    .nibble   (shadow_val[{idx, 2'b00} +: 4]),
    .dp       (shadow_dp[idx]),
    .suppress (suppress),
    .cathode  (dec_cathode)
  );

  always_ff @(posedge clk) begin
    if (!CPU_RESETN) begin
      cnt        <= '0;
      idx        <= 2'd0;
      state      <= BLANK;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_full  <= 1'b0;
      anode      <= ANODE_OFF;
      cathode    <= SEG_OFF;
    end else begin
      // Load and promote are exclusive: a load needs the pending slot empty
      if (value_valid_i && !pend_full) begin
        pend_val  <= value_i;
        pend_dp   <= dp_i;
        pend_full <= 1'b1;
      end else if (pend_full && (frame_end || !enable_i)) begin
        shadow_val <= pend_val;
        shadow_dp  <= pend_dp;
        pend_full  <= 1'b0;
      end

      if (!enable_i) begin
        cnt     <= '0;
        idx     <= 2'd0;
        state   <= BLANK;
        anode   <= ANODE_OFF;
        cathode <= SEG_OFF;
      end else begin
        cnt   <= cnt_n;
        state <= (cnt_n < CNT_BLANK) ? BLANK : DRIVE;
        if (wrap) idx <= idx + 2'd1;
        // Outputs lag the state by one cycle so anode and cathode move together
        if (state == DRIVE) begin
          anode   <= ~(4'b0001 << idx);
          cathode <= dec_cathode;
        end else begin
          anode   <= ANODE_OFF;
          cathode <= SEG_OFF;
        end
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl: 10-cycle slots, 2 blank cycles,
// 40-cycle frames; expected cathodes are hand-written hex codes.
module tb_sevenseg_scan_ctrl;

  logic        clk = 1'b0;
  logic        CPU_RESETN = 1'b0;
  logic        enable_i = 1'b1;
  logic        blank_lz_i = 1'b0;
  logic [15:0] value_i = 16'h0000;
  logic [3:0]  dp_i = 4'h0;
  logic        value_valid_i = 1'b0;
  logic        value_ready_o;
  logic [3:0]  anode;
  logic [7:0]  cathode;

  int tests = 0;
  int failed = 0;

  sevenseg_scan_ctrl #(
    .CLK_HZ       (1000),
    .REFRESH_HZ   (100),
    .BLANK_CYCLES (2)
  ) dut (
    .clk           (clk),
    .CPU_RESETN    (CPU_RESETN),
    .enable_i      (enable_i),
    .blank_lz_i    (blank_lz_i),
    .value_i       (value_i),
    .dp_i          (dp_i),
    .value_valid_i (value_valid_i),
    .value_ready_o (value_ready_o),
    .anode         (anode),
    .cathode       (cathode)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] a, input logic [7:0] c);
    chk(tag, {anode, cathode}, {a, c});
  endtask

  task automatic chk_rdy(input string tag, input logic r);
    chk(tag, {11'd0, value_ready_o}, {11'd0, r});
  endtask

  // Tick through frame positions first..last (p = digit*10 + slot cycle),
  // checking blank for the first 2 cycles of a slot, then the digit's code.
  task automatic frame(input string tag, input logic [7:0] c3, input logic [7:0] c2,
                       input logic [7:0] c1, input logic [7:0] c0,
                       input int first, input int last);
    logic [7:0] cs [4];
    logic [3:0] a;
    cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
    for (int p = first; p <= last; p++) begin
      tick();
      if (p % 10 < 2) begin
        chk_out(tag, 4'hF, 8'hFF);
      end else begin
        a = 4'b0001 << (p / 10);
        chk_out(tag, ~a, cs[p / 10]);
      end
    end
  endtask

  initial begin
    // 1: reset held with valid high
    value_i = 16'hFFFF;
    value_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("reset_out", 4'hF, 8'hFF);
      chk_rdy("reset_rdy", 1'b1);
    end
    value_valid_i = 1'b0;
    CPU_RESETN = 1'b1;

    // 2: scan of zero value
    frame("scan_zero", 8'hC0, 8'hC0, 8'hC0, 8'hC0, 0, 39);

    // 3: load 1234 with dp on digit 1, visible only after next boundary
    value_i = 16'h1234; dp_i = 4'b0010; value_valid_i = 1'b1;
    tick();
    chk_out("load1234_p0", 4'hF, 8'hFF);
    chk_rdy("load1234_busy", 1'b0);
    value_valid_i = 1'b0;
    frame("old_frame", 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1, 39);
    chk_rdy("load1234_promoted", 1'b1);
    frame("show1234", 8'hF9, 8'hA4, 8'h30, 8'h99, 0, 39);

    // 4: AAAA then BBBB back to back
    value_i = 16'hAAAA; dp_i = 4'b0000; value_valid_i = 1'b1;
    tick();
    chk_out("aaaa_p0", 4'hF, 8'hFF);
    chk_rdy("aaaa_busy", 1'b0);
    value_i = 16'hBBBB;
    frame("hold1234", 8'hF9, 8'hA4, 8'h30, 8'h99, 1, 29);
    chk_rdy("bbbb_stalled", 1'b0);
    frame("hold1234", 8'hF9, 8'hA4, 8'h30, 8'h99, 30, 39);
    chk_rdy("boundary_ready", 1'b1);
    tick();
    chk_out("aaaa_frame_p0", 4'hF, 8'hFF);
    chk_rdy("bbbb_taken", 1'b0);
    value_valid_i = 1'b0;
    frame("showAAAA", 8'h88, 8'h88, 8'h88, 8'h88, 1, 39);
    frame("showBBBB", 8'h83, 8'h83, 8'h83, 8'h83, 0, 39);

    // 5: leading-zero suppression
    blank_lz_i = 1'b1;
    value_i = 16'h0050; value_valid_i = 1'b1;
    tick();
    chk_out("lz_load_p0", 4'hF, 8'hFF);
    value_valid_i = 1'b0;
    frame("lz_bbbb", 8'h83, 8'h83, 8'h83, 8'h83, 1, 39);
    frame("lz_0050", 8'hFF, 8'hFF, 8'h92, 8'hC0, 0, 39);
    value_i = 16'h0000; value_valid_i = 1'b1;
    tick();
    chk_out("lz_load0_p0", 4'hF, 8'hFF);
    value_valid_i = 1'b0;
    frame("lz_0050b", 8'hFF, 8'hFF, 8'h92, 8'hC0, 1, 39);
    frame("lz_0000", 8'hFF, 8'hFF, 8'hFF, 8'hC0, 0, 39);

    // 6: reset mid-frame drops the pending value
    blank_lz_i = 1'b0;
    value_i = 16'h9999; value_valid_i = 1'b1;
    tick();
    chk_out("rst_load_p0", 4'hF, 8'hFF);
    value_valid_i = 1'b0;
    frame("pre_rst", 8'hC0, 8'hC0, 8'hC0, 8'hC0, 1, 24);
    CPU_RESETN = 1'b0;
    tick();
    chk_out("midrst_out", 4'hF, 8'hFF);
    chk_rdy("midrst_rdy", 1'b1);
    CPU_RESETN = 1'b1;
    frame("post_rst", 8'hC0, 8'hC0, 8'hC0, 8'hC0, 0, 39);
    frame("pend_lost", 8'hC0, 8'hC0, 8'hC0, 8'hC0, 0, 39);

    // disable mid-frame; a value loaded while dark is promoted at once
    frame("pre_dis", 8'hC0, 8'hC0, 8'hC0, 8'hC0, 0, 14);
    enable_i = 1'b0;
    value_i = 16'h0007; value_valid_i = 1'b1;
    tick();
    chk_out("dis_dark", 4'hF, 8'hFF);
    chk_rdy("dis_loaded", 1'b0);
    value_valid_i = 1'b0;
    tick();
    chk_out("dis_dark", 4'hF, 8'hFF);
    chk_rdy("dis_promoted", 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("dis_dark", 4'hF, 8'hFF);
    end
    enable_i = 1'b1;
    frame("reenable", 8'hC0, 8'hC0, 8'hC0, 8'hF8, 0, 39);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
